// File: rtl/icache_nway.sv
// Parametrised set-associative instruction cache with tree-pLRU or round-robin
// replacement, beat-wise line refill, whole-cache flush and saturating counters.
module icache_nway #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned REPL       = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_req_ready_i,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rsp_data_i,
  output logic [31:0]       no_acc_o,
  output logic [31:0]       no_hit_o,
  output logic [31:0]       no_miss_o,
  output logic              accessing_o
);

  localparam int unsigned WSEL_W   = $clog2(LINE_WORDS);
  localparam int unsigned OFF      = WSEL_W + 2;
  localparam int unsigned IDX_W    = $clog2(SETS);
  localparam int unsigned TAG_W    = ADDR_W - OFF - IDX_W;
  localparam int unsigned LOG_WAYS = $clog2(WAYS);
  localparam int unsigned WAY_W    = (WAYS > 1) ? LOG_WAYS : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MISS_REQ = 3'd2;
  localparam logic [2:0] S_REFILL   = 3'd3;
  localparam logic [2:0] S_RESP     = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;

  logic [2:0]        state_q;
  logic [ADDR_W-1:2] addr_q;
  logic [WSEL_W-1:0] beat_q;
  logic [IDX_W-1:0]  flush_idx_q;
  logic              flush_pend_q;
  logic [WAY_W-1:0]  victim_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [31:0]       acc_q;
  logic [31:0]       hit_q;
  logic [31:0]       miss_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   plru_q  [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];
  logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
  logic [31:0]       data_mem[WAYS][SETS*LINE_WORDS];

  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  idx;
  logic [WSEL_W-1:0] wsel;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [31:0]       hit_word;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  victim;
  logic              last_beat;
  logic              unused_addr_lsb;

  assign tag       = addr_q[ADDR_W-1 -: TAG_W];
  assign idx       = addr_q[OFF +: IDX_W];
  assign wsel      = addr_q[2 +: WSEL_W];
  assign last_beat = (beat_q == WSEL_W'(LINE_WORDS - 1));
  assign unused_addr_lsb = ^req_addr_i[1:0];

  // Heap-ordered tree (node 1 is the root); each node bit points at the
  // subtree to evict from next.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] bits);
    logic [WAY_W:0] node;
    node = (WAY_W + 1)'(1);
    for (int unsigned l = 0; l < LOG_WAYS; l++)
      node = {node[WAY_W-1:0], bits[node[WAY_W-1:0]]};
    return node[WAY_W-1:0];
  endfunction

  function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] w_sh;
    logic [WAYS-1:0]  res;
    logic             d;
    res  = bits;
    node = (WAY_W + 1)'(1);
    w_sh = way;
    for (int unsigned l = 0; l < LOG_WAYS; l++) begin
      d    = w_sh[WAY_W-1];
      res[node[WAY_W-1:0]] = ~d;
      node = {node[WAY_W-1:0], d};
      w_sh = w_sh << 1;
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_mem[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    if (WAYS == 1)
      victim = '0;
    else if (inv_found)
      victim = inv_way;
    else if (REPL == 0)
      victim = plru_victim(plru_q[idx]);
    else
      victim = rr_q[idx];
  end

  assign hit_word = data_mem[hit_way][{idx, wsel}];

  assign req_ready_o     = !rst_i && (state_q == S_IDLE) && !flush_pend_q && !flush_i;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign flush_busy_o    = (state_q == S_FLUSH);
  assign mem_req_valid_o = (state_q == S_MISS_REQ);
  assign mem_req_addr_o  = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign no_acc_o        = acc_q;
  assign no_hit_o        = hit_q;
  assign no_miss_o       = miss_q;
  assign accessing_o     = (state_q != S_IDLE);

  // Line storage carries no reset; only the valid bits qualify its contents.
  always_ff @(posedge clk_i) begin
    if ((state_q == S_REFILL) && mem_rsp_valid_i) begin
      data_mem[victim_q][{idx, beat_q}] <= mem_rsp_data_i;
      if (last_beat)
        tag_mem[victim_q][idx] <= tag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      flush_idx_q  <= '0;
      flush_pend_q <= 1'b0;
      victim_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      acc_q        <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      rsp_valid_q <= 1'b0;
      if (flush_i && (state_q != S_IDLE))
        flush_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (flush_i || flush_pend_q) begin
            state_q      <= S_FLUSH;
            flush_idx_q  <= '0;
            flush_pend_q <= 1'b0;
          end else if (req_valid_i) begin
            addr_q  <= req_addr_i[ADDR_W-1:2];
            acc_q   <= sat_inc(acc_q);
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_q       <= sat_inc(hit_q);
            rsp_data_q  <= hit_word;
            rsp_valid_q <= 1'b1;
            plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
            state_q     <= S_IDLE;
          end else begin
            miss_q   <= sat_inc(miss_q);
            victim_q <= victim;
            state_q  <= S_MISS_REQ;
          end
        end
        S_MISS_REQ: begin
          if (mem_req_ready_i) begin
            beat_q  <= '0;
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_rsp_valid_i) begin
            beat_q <= beat_q + 1'b1;
            // Requested word is captured as it streams past, so RESP needs no array read.
            if (beat_q == wsel)
              rsp_data_q <= mem_rsp_data_i;
            if (last_beat) begin
              valid_q[idx][victim_q] <= 1'b1;
              plru_q[idx]            <= plru_touch(plru_q[idx], victim_q);
              rr_q[idx]              <= rr_q[idx] + 1'b1;
              rsp_valid_q            <= 1'b1;
              state_q                <= S_RESP;
            end
          end
        end
        S_RESP: state_q <= S_IDLE;
        S_FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          plru_q[flush_idx_q]  <= '0;
          rr_q[flush_idx_q]    <= '0;
          flush_idx_q          <= flush_idx_q + 1'b1;
          if (flush_idx_q == IDX_W'(SETS - 1))
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: fetch responses are queued when issued and
// compared when rsp_valid_o fires; the bench plays the memory side by hand.
module tb_icache_nway;

  logic        clk;
  logic        rst_i;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        flush_i;
  logic        flush_busy_o;
  logic        mem_req_valid_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_ready_i;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic [31:0] no_acc_o;
  logic [31:0] no_hit_o;
  logic [31:0] no_miss_o;
  logic        accessing_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb_q[$];

  icache_nway #(.ADDR_W(32), .WAYS(4), .SETS(64), .LINE_WORDS(4), .REPL(0)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_addr_i      (req_addr_i),
    .req_ready_o     (req_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .flush_i         (flush_i),
    .flush_busy_o    (flush_busy_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .no_acc_o        (no_acc_o),
    .no_hit_o        (no_hit_o),
    .no_miss_o       (no_miss_o),
    .accessing_o     (accessing_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Backing memory: word at 0x100 reads 0xA0, each following word one higher.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_00A0 + {2'b00, a[31:2]} - 32'h40;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid_o) begin
      check("rsp_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0)
        check("rsp_data", rsp_data_o, sb_q.pop_front());
    end
  end

  task automatic fetch(input logic [31:0] a, input bit miss, input int rdly, input int gap,
                       input bit flush_mid, input int abort_at);
    int          n;
    bit          early;
    bit          stable;
    logic [31:0] base;
    base = a & ~32'hF;
    sb_q.push_back(mem_word(a));
    n = 0;
    while (!req_ready_o && n < 200) begin tick(); n++; end
    check("req_ready_seen", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    tick();
    req_valid_i = 1'b0;
    if (!miss) begin
      check("hit_no_memreq_lookup", 32'(mem_req_valid_o), 32'd0);
      tick();
      check("hit_rsp_lat2", 32'(rsp_valid_o), 32'd1);
      check("hit_no_memreq", 32'(mem_req_valid_o), 32'd0);
    end else begin
      early = 1'b0;
      n = 0;
      while (!mem_req_valid_o && n < 20) begin early |= rsp_valid_o; tick(); n++; end
      check("memreq_seen", 32'(mem_req_valid_o), 32'd1);
      check("memreq_addr", mem_req_addr_o, base);
      stable = 1'b1;
      repeat (rdly) begin
        tick();
        if (!mem_req_valid_o || mem_req_addr_o !== base) stable = 1'b0;
      end
      if (rdly > 0) check("memreq_stable", 32'(stable), 32'd1);
      mem_req_ready_i = 1'b1;
      tick();
      mem_req_ready_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
        if (flush_mid && b == 2) begin
          flush_i = 1'b1;
          tick();
          flush_i = 1'b0;
        end
        repeat (gap) begin early |= rsp_valid_o; tick(); end
        early |= rsp_valid_o;
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = mem_word(base + 32'(4 * b));
        tick();
        mem_rsp_valid_i = 1'b0;
        if (abort_at > 0 && b == abort_at - 1) begin
          rst_i = 1'b1;
          #1;
          check("rst_ready", 32'(req_ready_o), 32'd0);
          check("rst_accessing", 32'(accessing_o), 32'd0);
          check("rst_memreq", 32'(mem_req_valid_o), 32'd0);
          check("rst_rsp_data", rsp_data_o, 32'd0);
          check("rst_miss_cnt", no_miss_o, 32'd0);
          check("rst_acc_cnt", no_acc_o, 32'd0);
          tick();
          tick();
          rst_i = 1'b0;
          sb_q.delete();
          repeat (2) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = 32'hBAD0_0BAD;
            tick();
            mem_rsp_valid_i = 1'b0;
            check("late_beat_idle", 32'(accessing_o | rsp_valid_o), 32'd0);
          end
          return;
        end
      end
      check("no_early_rsp", 32'(early), 32'd0);
      check("miss_rsp_lat1", 32'(rsp_valid_o), 32'd1);
    end
    tick();
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_cnt(input string tag, input int acc, input int hits, input int misses);
    check({tag, "_acc"}, no_acc_o, 32'(acc));
    check({tag, "_hit"}, no_hit_o, 32'(hits));
    check({tag, "_miss"}, no_miss_o, 32'(misses));
  endtask

  // Set 0 is filled in the order 0x0000, 0x0800, 0x0400, 0x0C00 so that after
  // re-touching 0x0000 the pLRU tree points at 0x0400 (way 2).
  logic [31:0] t3_addr [9] = '{32'h0000, 32'h0800, 32'h0400, 32'h0C00, 32'h0000,
                               32'h1000, 32'h0000, 32'h0400, 32'h0800};
  bit          t3_miss [9] = '{1, 1, 1, 1, 0, 1, 0, 1, 0};

  initial begin
    int n;
    int busy;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; flush_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (3) tick();
    check("reset_ready", 32'(req_ready_o), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_memreq", 32'(mem_req_valid_o), 32'd0);
    check("reset_flush_busy", 32'(flush_busy_o), 32'd0);
    check("reset_accessing", 32'(accessing_o), 32'd0);
    check_cnt("reset", 0, 0, 0);
    rst_i = 1'b0;
    tick();
    check("ready_after_reset", 32'(req_ready_o), 32'd1);

    fetch(32'h0000_0104, 1, 0, 0, 0, 0);
    check_cnt("t1", 1, 0, 1);
    fetch(32'h0000_010C, 0, 0, 0, 0, 0);
    check_cnt("t2", 2, 1, 1);

    for (int i = 0; i < 9; i++) fetch(t3_addr[i], t3_miss[i], 0, 0, 0, 0);
    check_cnt("t3", 11, 4, 7);

    fetch(32'h0000_0208, 1, 5, 3, 0, 0);

    fetch(32'h0000_0304, 1, 0, 2, 1, 0);
    n = 0;
    while (!flush_busy_o && n < 20) begin tick(); n++; end
    check("flush_ready_low", 32'(req_ready_o), 32'd0);
    busy = 0;
    while (flush_busy_o && busy < 200) begin busy++; tick(); end
    check("flush_cycles", 32'(busy), 32'd64);
    fetch(32'h0000_010C, 1, 0, 0, 0, 0);
    check_cnt("t5", 14, 4, 10);

    fetch(32'h0000_0504, 1, 0, 1, 0, 2);
    fetch(32'h0000_0504, 1, 0, 0, 0, 0);
    check_cnt("t6", 1, 0, 1);
    fetch(32'h0000_0500, 0, 0, 0, 0, 0);
    check_cnt("t6_hit", 2, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
